// File: rtl/learn_tone_gen.sv
// -----------------------------------------------------------------------------
// learn_tone_gen
//   Audio back end for the learning / auto-play modes. Turns a 5-bit note code
//   plus a play request into a glitch-free square wave on the board buzzer.
//   Note changes and gating only take effect on half-period boundaries, so the
//   speaker never emits a short pulse or a click.
//
// Parameters
//   CLK_HZ   system clock frequency; the half-period table is specified for
//            100 MHz and is rescaled to CLK_HZ at elaboration
//   CNT_W    half-period counter width (20 covers low C at 100 MHz)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   music  [4:0] in   note code: 0 rest, 1-7 low C..B, 8-14 mid, 15-21 high,
//                     22-31 treated as rest
//   gate         in   play request; sound only while high
//   mute         in   synchronous mute, same effect as gate=0
//   vol    [1:0] in   (TONE_VOLUME_EN only) PWM volume on the high half
//   speaker      out  buzzer drive
//   aud_sd       out  amplifier enable, high while a note is sounding
//   note_active  out  high while the speaker is toggling
//   cur_note     out  code currently being played, 0 when silent
//
// Build option
//   TONE_VOLUME_EN  when defined, adds vol[1:0]; the high half of the square
//                   wave is chopped by a 64-cycle PWM carrier.
// -----------------------------------------------------------------------------
module learn_tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] music,
    input  logic       gate,
    input  logic       mute,
`ifdef TONE_VOLUME_EN
    input  logic [1:0] vol,
`endif
    output logic       speaker,
    output logic       aud_sd,
    output logic       note_active,
    output logic [4:0] cur_note
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Rescale a 100 MHz half-period to the actual clock (floor).
    function automatic logic [CNT_W-1:0] scale(input longint hp100);
        longint scaled;
        scaled = (hp100 * longint'(CLK_HZ)) / 64'sd100_000_000;
        return CNT_W'(scaled);
    endfunction

    // Mid-octave half-periods in clock cycles.
    localparam logic [CNT_W-1:0] MID_C = scale(190840);
    localparam logic [CNT_W-1:0] MID_D = scale(170068);
    localparam logic [CNT_W-1:0] MID_E = scale(151515);
    localparam logic [CNT_W-1:0] MID_F = scale(143266);
    localparam logic [CNT_W-1:0] MID_G = scale(127551);
    localparam logic [CNT_W-1:0] MID_A = scale(113636);
    localparam logic [CNT_W-1:0] MID_B = scale(101215);

    // Half-period lookup for a valid note code. Low octave doubles the mid
    // value, high octave halves it (floor). Rest codes never reach here while
    // sounding, so their result is don't-care.
    function automatic logic [CNT_W-1:0] half_of(input logic [4:0] code);
        logic [4:0]       deg;
        logic [1:0]       oct;
        logic [CNT_W-1:0] mid;
        if (code >= 5'd15) begin
            oct = 2'd2;
            deg = code - 5'd15;
        end else if (code >= 5'd8) begin
            oct = 2'd1;
            deg = code - 5'd8;
        end else begin
            oct = 2'd0;
            deg = code - 5'd1;
        end
        case (deg)
            5'd0:    mid = MID_C;
            5'd1:    mid = MID_D;
            5'd2:    mid = MID_E;
            5'd3:    mid = MID_F;
            5'd4:    mid = MID_G;
            5'd5:    mid = MID_A;
            default: mid = MID_B;
        endcase
        case (oct)
            2'd0:    return mid << 1;
            2'd1:    return mid;
            default: return mid >> 1;
        endcase
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic             sq;        // raw square wave
    logic             note_ok;
    logic             want;
    logic             boundary;

    assign note_ok  = (music != 5'd0) && (music <= 5'd21);
    assign want     = gate & ~mute & note_ok;
    assign half     = half_of(cur_note);
    // Last cycle of the current half-period; only meaningful in PLAY/DRAIN.
    assign boundary = (cnt == half - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sq          <= 1'b0;
            cur_note    <= 5'd0;
            note_active <= 1'b0;
            aud_sd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sq  <= 1'b0;
                    cnt <= '0;
                    if (want) begin
                        cur_note    <= music;
                        note_active <= 1'b1;
                        aud_sd      <= 1'b1;
                        state       <= PLAY;
                    end
                end

                PLAY: begin
                    if (boundary) begin
                        sq  <= ~sq;
                        cnt <= '0;
                        // Losing the request beats a simultaneous code change.
                        if (!want) begin
                            state <= DRAIN;
                        end else if (music != cur_note) begin
                            // New period starts right after this toggle.
                            cur_note <= music;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DRAIN: begin
                    // A high output finishes a full half-period before it is
                    // pulled low; a low output shuts down immediately. The
                    // request is ignored until IDLE.
                    if (sq && !boundary) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        sq          <= 1'b0;
                        cnt         <= '0;
                        cur_note    <= 5'd0;
                        note_active <= 1'b0;
                        aud_sd      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef TONE_VOLUME_EN
    // 64-cycle PWM carrier, phase-aligned to each half-period boundary so
    // every high half starts with the carrier high.
    logic [5:0] pwm_cnt;
    logic [6:0] duty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= 6'd0;
        end else if (state == IDLE || boundary) begin
            pwm_cnt <= 6'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 6'd1;
        end
    end

    // (vol+1)*16 high cycles out of 64; vol=3 gives 64, a solid high.
    assign duty    = ({5'd0, vol} + 7'd1) << 4;
    assign speaker = sq & ({1'b0, pwm_cnt} < duty);
`else
    assign speaker = sq;
`endif

endmodule
